sample_player: RTL and testbench

- Synthesizable successor to the bench-side sample feeder; replaces the fixed "one sample every 5 clocks from a RAM" behaviour.
- Replays IQ samples from an internal buffer into dot11 (sample_in/sample_in_strobe) for on-chip loopback and self-test.
- Adds parametrised width and depth, a programmable strobe interval, start offset, sample count, loop mode, pause and abort.
- Configured through the standard set_stb/set_addr/set_data settings bus.

---
 rtl/sample_player.sv | 137 +++++++++++++
 tb/tb_sample_player.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sample_player.sv
// IQ sample replay engine: plays a programmable window of an internal buffer into a
// strobed sample stream, with loop, pause and abort, configured over the settings bus.
module sample_player #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [7:0]  SR_BASE    = 8'd32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  set_stb,
    input  logic [7:0]            set_addr,
    input  logic [31:0]           set_data,
    input  logic                  wr_stb,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  start,
    input  logic                  stop,
    output logic [DATA_WIDTH-1:0] sample_out,
    output logic                  sample_out_strobe,
    output logic [ADDR_WIDTH:0]   sample_idx,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e r_state, w_state_next;

    logic [15:0]           r_period, r_period_sh, r_cnt;
    logic [ADDR_WIDTH:0]   r_num, r_num_sh, r_k;
    logic [ADDR_WIDTH-1:0] r_start, r_start_sh, r_addr;
    logic                  r_loop, r_loop_sh;

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] r_pref;
    logic [DATA_WIDTH-1:0] r_sample_out;
    logic                  r_strobe;
    logic [ADDR_WIDTH:0]   r_sample_idx;

    logic                  w_accept, w_pass_end, w_last, w_fire;
    logic [ADDR_WIDTH:0]   w_num_m1;
    logic [ADDR_WIDTH-1:0] w_next_addr, w_rd_addr;
    logic                  w_unused_set_data;

    assign w_unused_set_data = ^set_data[31:16];

    assign w_accept    = (r_state == S_IDLE) && enable && start && !stop;
    // In a non-loop pass r_k reaches NUM one cycle before the move to S_DONE.
    assign w_pass_end  = (r_k == r_num_sh);
    assign w_num_m1    = r_num_sh - 1'b1;
    assign w_last      = (r_k == w_num_m1);
    assign w_fire      = (r_state == S_RUN) && enable && !stop && !w_pass_end &&
                         (r_cnt == r_period_sh);
    assign w_next_addr = (w_last && r_loop_sh) ? r_start_sh : r_addr + 1'b1;
    // Prefetch the sample the next strobe will need so PERIOD=0 runs at full rate.
    assign w_rd_addr   = w_accept ? r_start : (w_fire ? w_next_addr : r_addr);

    always_ff @(posedge clock) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_accept) w_state_next = (r_num == '0) ? S_DONE : S_RUN;
            S_RUN: begin
                if (enable) begin
                    if (stop)            w_state_next = S_IDLE;
                    else if (w_pass_end) w_state_next = S_DONE;
                end
            end
            S_DONE: if (enable) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_RUN);
        done = (r_state == S_DONE);
    end

    always_ff @(posedge clock) begin
        if (wr_stb) r_mem[wr_addr] <= wr_data;
        r_pref <= r_mem[w_rd_addr];
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_period     <= 16'd4;
            r_num        <= '0;
            r_start      <= '0;
            r_loop       <= 1'b0;
            r_period_sh  <= 16'd4;
            r_num_sh     <= '0;
            r_start_sh   <= '0;
            r_loop_sh    <= 1'b0;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_k          <= '0;
            r_sample_out <= '0;
            r_strobe     <= 1'b0;
            r_sample_idx <= '0;
        end else begin
            if (set_stb) begin
                if (set_addr == SR_BASE)         r_period <= set_data[15:0];
                if (set_addr == SR_BASE + 8'd1)  r_num    <= set_data[ADDR_WIDTH:0];
                if (set_addr == SR_BASE + 8'd2)  r_start  <= set_data[ADDR_WIDTH-1:0];
                if (set_addr == SR_BASE + 8'd3)  r_loop   <= set_data[0];
            end
            if (w_accept) begin
                r_period_sh <= r_period;
                r_num_sh    <= r_num;
                r_start_sh  <= r_start;
                r_loop_sh   <= r_loop;
                r_cnt       <= '0;
                r_addr      <= r_start;
                r_k         <= '0;
            end else if (r_state == S_RUN && enable) begin
                r_cnt <= (r_cnt == r_period_sh) ? '0 : r_cnt + 1'b1;
            end
            r_strobe <= w_fire;
            if (w_fire) begin
                r_sample_out <= r_pref;
                r_sample_idx <= r_k;
                r_addr       <= w_next_addr;
                r_k          <= (w_last && r_loop_sh) ? '0 : r_k + 1'b1;
            end
        end
    end

    assign sample_out        = r_sample_out;
    assign sample_out_strobe = r_strobe;
    assign sample_idx        = r_sample_idx;

endmodule

// File: tb/tb_sample_player.sv
// Randomised self-checking bench for sample_player: expected strobe times, data and
// indices come from the closed-form timing rule and a shadow copy of the buffer.
module tb_sample_player;

    localparam logic [7:0] SR = 8'd32;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b1;
    logic        set_stb = 1'b0;
    logic [7:0]  set_addr = '0;
    logic [31:0] set_data = '0;
    logic        wr_stb = 1'b0;
    logic [9:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] sample_out;
    logic        sample_out_strobe;
    logic [10:0] sample_idx;
    logic        busy;
    logic        done;

    sample_player dut (
        .clock             (clock),
        .reset             (reset),
        .enable            (enable),
        .set_stb           (set_stb),
        .set_addr          (set_addr),
        .set_data          (set_data),
        .wr_stb            (wr_stb),
        .wr_addr           (wr_addr),
        .wr_data           (wr_data),
        .start             (start),
        .stop              (stop),
        .sample_out        (sample_out),
        .sample_out_strobe (sample_out_strobe),
        .sample_idx        (sample_idx),
        .busy              (busy),
        .done              (done)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int          total = 0;
    int          bad = 0;
    logic [31:0] mem_m [1024];
    int          obs_cyc [$];
    logic [31:0] obs_dat [$];
    int          obs_idx [$];
    int          done_cyc [$];

    always @(negedge clock) begin
        if (reset) begin
            if (sample_out_strobe) begin
                obs_cyc.push_back(cyc);
                obs_dat.push_back(sample_out);
                obs_idx.push_back(int'(sample_idx));
            end
            if (done) done_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic set_reg(input int off, input logic [31:0] val);
        set_stb  = 1'b1;
        set_addr = SR + 8'(off);
        set_data = val;
        tick();
        set_stb  = 1'b0;
    endtask

    task automatic buf_wr(input int a, input logic [31:0] d);
        wr_stb  = 1'b1;
        wr_addr = 10'(a);
        wr_data = d;
        mem_m[a % 1024] = d;
        tick();
        wr_stb  = 1'b0;
    endtask

    task automatic chk_zero_outputs(input string pfx);
        chk({pfx, "_strobe"}, sample_out_strobe, 0);
        chk({pfx, "_data"}, sample_out, 0);
        chk({pfx, "_idx"}, sample_idx, 0);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_done"}, done, 0);
    endtask

    // p is the period the run is expected to use; wr_p selects whether it is written first.
    task automatic do_run(input int p, input int n, input int s, input int lp, input bit wr_p,
                          input int pause_k, input int pause_len, input int stop_k,
                          input int mw_k, input int rst_k);
        int e0, budget, left, tail, n_exp, mn, ecyc, edone;
        bit paused, stopped, mwd, rsted, finished;
        paused = 0; stopped = 0; mwd = 0; rsted = 0; finished = 0;
        left = 0; tail = -1;
        if (wr_p) set_reg(0, p);
        set_reg(1, n);
        set_reg(2, s);
        set_reg(3, lp);
        set_reg(4, $urandom);
        obs_cyc.delete(); obs_dat.delete(); obs_idx.delete(); done_cyc.delete();
        start = 1'b1;
        e0 = cyc + 1;
        tick();
        start = 1'b0;
        budget = (n + 2) * (p + 1) + pause_len + 40;
        for (int c = 0; c < budget && !finished; c++) begin
            set_stb = 1'b0;
            if (stop) begin
                stop = 1'b0;
                chk("stop_busy", busy, 0);
            end
            if (!reset) begin
                reset = 1'b1;
                chk_zero_outputs("midrst");
            end
            if (!enable) begin
                left--;
                if (left <= 0) enable = 1'b1;
            end
            if (!paused && pause_k >= 0 && obs_cyc.size() == pause_k + 1) begin
                enable = 1'b0; left = pause_len; paused = 1;
            end
            if (!stopped && stop_k >= 0 && obs_cyc.size() == stop_k + 1) begin
                stop = 1'b1; stopped = 1; tail = 12;
            end
            if (!mwd && mw_k >= 0 && obs_cyc.size() == mw_k + 1) begin
                set_stb = 1'b1; set_addr = SR; set_data = 32'd9; mwd = 1;
            end
            if (!rsted && rst_k >= 0 && obs_cyc.size() == rst_k + 1) begin
                reset = 1'b0; rsted = 1; tail = 12;
            end
            if (tail < 0 && done_cyc.size() > 0) tail = 6;
            if (tail == 0) finished = 1;
            else begin
                if (tail > 0) tail--;
                tick();
            end
        end
        set_stb = 1'b0;
        if (!finished) chk("timeout", 0, 1);

        n_exp = (stop_k >= 0) ? stop_k + 1 : (rst_k >= 0) ? rst_k + 1 : n;
        chk("count", obs_cyc.size(), n_exp);
        mn = (obs_cyc.size() < n_exp) ? obs_cyc.size() : n_exp;
        for (int k = 0; k < mn; k++) begin
            ecyc = e0 + (k + 1) * (p + 1) + ((pause_k >= 0 && k > pause_k) ? pause_len : 0);
            chk("strobe_cyc", obs_cyc[k], ecyc);
            chk("data", obs_dat[k], mem_m[(s + k % n) % 1024]);
            chk("idx", obs_idx[k], k % n);
        end
        if (lp == 0 && stop_k < 0 && rst_k < 0) begin
            chk("done_count", done_cyc.size(), 1);
            edone = (n == 0) ? e0 :
                    e0 + n * (p + 1) + 1 + ((pause_k >= 0 && pause_k < n - 1) ? pause_len : 0);
            if (done_cyc.size() > 0) chk("done_cyc", done_cyc[0], edone);
        end else begin
            chk("done_count", done_cyc.size(), 0);
        end
        chk("busy_end", busy, 0);
    endtask

    initial begin
        int p, n, s;
        repeat (3) tick();
        chk_zero_outputs("reset");
        reset = 1'b1;
        tick();

        for (int i = 0; i < 1024; i++) begin
            wr_stb  = 1'b1;
            wr_addr = 10'(i);
            wr_data = i;
            mem_m[i] = i;
            tick();
        end
        wr_stb = 1'b0;

        do_run(4, 8, 0, 0, 1, -1, 0, -1, -1, -1);      // basic
        do_run(0, 4, 1022, 0, 1, -1, 0, -1, -1, -1);   // full rate, address wrap
        do_run(1, 3, 0, 1, 1, -1, 0, 4, -1, -1);       // loop then stop
        do_run(4, 6, 0, 0, 1, 2, 7, -1, -1, -1);       // pause
        do_run(4, 0, 0, 0, 1, -1, 0, -1, -1, -1);      // NUM=0
        do_run(4, 6, 100, 0, 1, -1, 0, -1, 1, -1);     // PERIOD write mid-run
        do_run(9, 4, 0, 0, 0, -1, 0, -1, -1, -1);      // next run picks up 9
        do_run(9, 6, 0, 0, 0, -1, 0, -1, -1, 1);       // reset mid-run
        do_run(4, 3, 5, 0, 0, -1, 0, -1, -1, -1);      // defaults restored

        for (int r = 0; r < 6; r++) begin
            p = $urandom_range(0, 5);
            n = $urandom_range(1, 12);
            s = $urandom_range(0, 1023);
            for (int j = 0; j < 16; j++) buf_wr(s + $urandom_range(0, 15), $urandom);
            do_run(p, n, s, 0, 1, -1, 0, -1, -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
